// File: rtl/tick_gate.sv
// rtl/tick_gate.sv - divided-clock edge detector driving a valid/ready tick handshake
// Run/pause/single-step control, accepted-tick counter and saturating overrun counter.
module tick_gate #(
  parameter int CNT_W    = 16,
  parameter int OVR_W    = 8,
  parameter int MASK_CYC = 3
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             ClkIn,
  input  logic [3:0]       Level,
  input  logic             Run,
  input  logic             Step,
  input  logic             TickReady,
  output logic             TickValid,
  output logic [CNT_W-1:0] TickCount,
  output logic [OVR_W-1:0] Overrun,
  output logic [1:0]       State
);

  localparam int MW = $clog2(MASK_CYC + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STEP_WAIT = 2'd2
  } state_t;

  logic             s1_q, s2_q, s3_q;
  logic [3:0]       lvl_q, lvl_d;
  logic [MW-1:0]    mask_q, mask_d;
  state_t           state_q, state_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OVR_W-1:0] ovr_q, ovr_d;
  logic             evt, issue, accept;

  // Level 0 means the divider passes Clk straight through, so every cycle is an edge.
  assign evt    = (mask_q == '0) && ((Level == 4'd0) || (s2_q && !s3_q));
  assign accept = valid_q && TickReady;

  always_comb begin
    lvl_d  = lvl_q;
    mask_d = mask_q;
    if (Level != lvl_q) begin
      lvl_d  = Level;
      mask_d = MW'(MASK_CYC);
    end else if (mask_q != '0) begin
      mask_d = mask_q - MW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Run)       state_d = RUN;
        else if (Step) state_d = STEP_WAIT;
      end
      RUN: begin
        issue = evt;
        if (!Run) state_d = IDLE;
      end
      STEP_WAIT: begin
        if (Run) begin
          state_d = RUN;
        end else if (evt) begin
          issue   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q + CNT_W'(accept);
    if (issue) begin
      if (valid_q && !TickReady) begin
        if (ovr_q != '1) ovr_d = ovr_q + OVR_W'(1);
      end else begin
        valid_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      lvl_q   <= '0;
      mask_q  <= '0;
      state_q <= IDLE;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      ovr_q   <= '0;
    end else begin
      s1_q    <= ClkIn;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      lvl_q   <= lvl_d;
      mask_q  <= mask_d;
      state_q <= state_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  assign TickValid = valid_q;
  assign TickCount = cnt_q;
  assign Overrun   = ovr_q;
  assign State     = state_q;

endmodule

// File: tb/tb_tick_gate.sv
// tb/tb_tick_gate.sv - self-checking bench for tick_gate
// Edge-indexed reference model plus directed literal expectations.
module tb_tick_gate;
  localparam int MASK = 3;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        ClkIn = 1'b0;
  logic [3:0]  Level = 4'd1;
  logic        Run = 1'b0;
  logic        Step = 1'b0;
  logic        TickReady = 1'b0;
  logic        TickValid;
  logic [15:0] TickCount;
  logic [7:0]  Overrun;
  logic [1:0]  State;
  logic [15:0] c0;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  tick_gate #(.CNT_W(16), .OVR_W(8), .MASK_CYC(MASK)) dut (
    .Clk(Clk), .Rst(Rst), .ClkIn(ClkIn), .Level(Level), .Run(Run), .Step(Step),
    .TickReady(TickReady), .TickValid(TickValid), .TickCount(TickCount),
    .Overrun(Overrun), .State(State)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edges indexed by count, ClkIn history kept as a sample list.
  bit smp[$];
  bit m_valid, masked, seen, evt, issue, acc;
  int m_cnt, m_ovr, m_state, m_lvl, chg, e;

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_valid = 0; m_cnt = 0; m_ovr = 0; m_state = 0;
      smp = '{1'b0, 1'b0, 1'b0};
      m_lvl = 0; chg = -100; e = 0;
    end else begin
      e++;
      masked = (e > chg) && (e - chg <= MASK);
      seen   = smp[smp.size()-2] && !smp[smp.size()-3];
      evt    = !masked && ((Level == 4'd0) || seen);
      issue  = 0;
      case (m_state)
        0: if (Run) m_state = 1; else if (Step) m_state = 2;
        1: begin issue = evt; if (!Run) m_state = 0; end
        default: if (Run) m_state = 1; else if (evt) begin issue = 1; m_state = 0; end
      endcase
      acc = m_valid && TickReady;
      if (acc) m_cnt = (m_cnt + 1) % 65536;
      if (issue && m_valid && !TickReady) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
      else if (issue) m_valid = 1;
      else if (acc) m_valid = 0;
      if (int'(Level) != m_lvl) begin chg = e; m_lvl = int'(Level); end
      smp.push_back(ClkIn);
      if (smp.size() > 8) void'(smp.pop_front());
    end
  end

  always @(negedge Clk) begin
    if (Rst) begin
      chk("model_valid", 32'(TickValid), 32'(m_valid));
      chk("model_count", 32'(TickCount), m_cnt);
      chk("model_overrun", 32'(Overrun), m_ovr);
      chk("model_state", 32'(State), m_state);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic rise(input int h, input int l);
    ClkIn = 1'b1; cyc(h);
    ClkIn = 1'b0; cyc(l);
  endtask

  initial begin
    cyc(2);
    chk("reset_valid", 32'(TickValid), 0);
    chk("reset_state", 32'(State), 0);
    Rst = 1'b1;
    cyc(5);

    // free run with exact latency on the first rise
    Run = 1'b1; TickReady = 1'b1;
    cyc(2);
    chk("run_state", 32'(State), 1);
    ClkIn = 1'b1;
    cyc(1); chk("lat_after_k", 32'(TickValid), 0);
    cyc(1); chk("lat_after_k1", 32'(TickValid), 0);
    cyc(1); chk("lat_after_k2", 32'(TickValid), 1);
    cyc(1); chk("lat_after_k3", 32'(TickValid), 0);
    ClkIn = 1'b0; cyc(4);
    repeat (4) rise(4, 4);
    chk("free_count", 32'(TickCount), 5);
    chk("free_overrun", 32'(Overrun), 0);

    // async reset mid-run with a pending tick and count 7
    repeat (2) rise(4, 4);
    TickReady = 1'b0;
    rise(4, 4);
    chk("pre_reset_count", 32'(TickCount), 7);
    chk("pre_reset_valid", 32'(TickValid), 1);
    #1 Rst = 1'b0;
    #1;
    chk("async_valid", 32'(TickValid), 0);
    chk("async_count", 32'(TickCount), 0);
    chk("async_overrun", 32'(Overrun), 0);
    chk("async_state", 32'(State), 0);
    @(negedge Clk) Rst = 1'b1;
    #1 chk("release_state", 32'(State), 0);
    cyc(5);

    // back-pressure
    repeat (3) rise(4, 4);
    chk("bp_valid", 32'(TickValid), 1);
    chk("bp_overrun", 32'(Overrun), 2);
    chk("bp_count", 32'(TickCount), 0);
    TickReady = 1'b1; cyc(1); TickReady = 1'b0;
    chk("bp_drain_count", 32'(TickCount), 1);
    chk("bp_drain_valid", 32'(TickValid), 0);

    // single step, extra step pulse while waiting must not queue
    Run = 1'b0; cyc(2);
    chk("pause_state", 32'(State), 0);
    TickReady = 1'b1;
    Step = 1'b1; cyc(1); Step = 1'b0;
    chk("step_wait_state", 32'(State), 2);
    cyc(1); Step = 1'b1; cyc(1); Step = 1'b0;
    c0 = TickCount;
    repeat (4) rise(4, 4);
    chk("step_one_tick", 32'(TickCount - c0), 1);
    chk("step_back_idle", 32'(State), 0);
    Step = 1'b1; Run = 1'b1; cyc(1); Step = 1'b0;
    chk("step_run_priority", 32'(State), 1);
    Run = 1'b0; cyc(2);

    // pass-through
    Level = 4'd0; cyc(5);
    c0 = TickCount;
    Run = 1'b1; cyc(2);
    chk("pt_first_valid", 32'(TickValid), 1);
    cyc(10);
    chk("pt_count", 32'(TickCount - c0), 10);
    chk("pt_valid", 32'(TickValid), 1);
    Run = 1'b0; cyc(3);

    // level change masks an edge landing right after it
    Level = 4'd1; cyc(5);
    Run = 1'b1; cyc(2);
    c0 = TickCount;
    Level = 4'd2; cyc(1);
    rise(4, 4);
    chk("mask_no_tick", 32'(TickCount - c0), 0);
    rise(4, 4);
    chk("post_mask_tick", 32'(TickCount - c0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
